fifo_ctrl_param: RTL and testbench

Parametrised pointer, occupancy and flag controller for a single-clock FIFO. It manages both the write side and the read side of an external dual-port RAM. It generates RAM write/read strobes and addresses, tracks occupancy, and reports full, empty, almost-full, almost-empty, overflow and underflow. It sits between producer/consumer handshakes and the storage array in the buffering datapath.

---
 rtl/fifo_ctrl_param_if.sv | 30 +++
 rtl/fifo_ctrl_param.sv | 94 +++++++++
 tb/tb_fifo_ctrl_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_param_if.sv
// Handshake and RAM-control bundle between a FIFO's producer/consumer/storage and
// its pointer controller. The master drives requests, the slave answers with strobes and flags.
interface fifo_ctrl_param_if #(parameter int ADDR_W = 4);
  logic              wr_req;
  logic              rd_req;
  logic              err_clr;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              afull;
  logic              aempty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_req, rd_req, err_clr,
    input  wr_en_o, wr_addr, rd_en_o, rd_addr, count,
    input  full, empty, afull, aempty, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output wr_en_o, wr_addr, rd_en_o, rd_addr, count,
    output full, empty, afull, aempty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Pointer/occupancy/flag controller for a single-clock FIFO backed by an external dual-port RAM.
// Optional macro STICKY_ERR_EN makes overflow/underflow sticky until err_clr.
module fifo_ctrl_param #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_ctrl_param_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              full_w, empty_w;
  logic              wr_acc, rd_acc;
  logic              ovf_ev, udf_ev;
  logic              ovf_q, udf_q;

  assign full_w  = (cnt == DEPTH_C);
  assign empty_w = (cnt == '0);
  // Acceptance is judged on start-of-cycle occupancy, so a full FIFO rejects a
  // write even when a read drains it in the same cycle.
  assign wr_acc  = bus.wr_req & ~full_w;
  assign rd_acc  = bus.rd_req & ~empty_w;
  assign ovf_ev  = bus.wr_req & full_w;
  assign udf_ev  = bus.rd_req & empty_w;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths address only valid rows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef STICKY_ERR_EN
  // A new event in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev | (ovf_q & ~bus.err_clr);
      udf_q <= udf_ev | (udf_q & ~bus.err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev;
      udf_q <= udf_ev;
    end
  end
`endif

  assign bus.wr_en_o   = wr_acc;
  assign bus.rd_en_o   = rd_acc;
  assign bus.wr_addr   = wr_ptr;
  assign bus.rd_addr   = rd_ptr;
  assign bus.count     = cnt;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.afull     = (cnt >= AFULL_C);
  assign bus.aempty    = (cnt <= AEMPTY_C);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Randomised and directed bench for fifo_ctrl_param: a 16-deep and a 10-deep instance
// share stimulus and are each compared every cycle with an occupancy/pointer reference model.
module tb_fifo_ctrl_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr = 1'b0, rd = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_param_if #(.ADDR_W(4)) b0 ();
  fifo_ctrl_param_if #(.ADDR_W(4)) b1 ();
  assign b0.wr_req = wr;  assign b0.rd_req = rd;  assign b0.err_clr = clr;
  assign b1.wr_req = wr;  assign b1.rd_req = rd;  assign b1.err_clr = clr;

  fifo_ctrl_param #(.DEPTH(16), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  fifo_ctrl_param #(.DEPTH(10), .ADDR_W(4), .AFULL_TH(8), .AEMPTY_TH(1))
    u1 (.clk(clk), .reset(reset), .bus(b1));

`ifdef STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] cnt;
    logic [3:0] wa;
    logic [3:0] ra;
    logic full, empty, afull, aempty, ovf, udf;
  } st_t;

  int checks = 0, failures = 0;
  int D [2]  = '{16, 10};
  int AF[2]  = '{12, 8};
  int AE[2]  = '{2, 1};
  int m_cnt[2], m_wp[2], m_rp[2];
  bit m_ovf[2], m_udf[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
    end
  endtask

  // Reference: occupancy as an integer, pointers as modulo-DEPTH counters.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit f, e, wa, ra;
      f  = (m_cnt[k] == D[k]);
      e  = (m_cnt[k] == 0);
      wa = wr && !f;
      ra = rd && !e;
      m_cnt[k] = m_cnt[k] + int'(wa) - int'(ra);
      if (wa) m_wp[k] = (m_wp[k] + 1) % D[k];
      if (ra) m_rp[k] = (m_rp[k] + 1) % D[k];
      m_ovf[k] = (wr && f) || (STICKY && m_ovf[k] && !clr);
      m_udf[k] = (rd && e) || (STICKY && m_udf[k] && !clr);
    end
  endtask

  function automatic st_t exp_st(int k);
    st_t s;
    s.cnt = 5'(m_cnt[k]); s.wa = 4'(m_wp[k]); s.ra = 4'(m_rp[k]);
    s.full = (m_cnt[k] == D[k]); s.empty = (m_cnt[k] == 0);
    s.afull = (m_cnt[k] >= AF[k]); s.aempty = (m_cnt[k] <= AE[k]);
    s.ovf = m_ovf[k]; s.udf = m_udf[k];
    return s;
  endfunction

  function automatic st_t obs_st(int k);
    st_t s;
    if (k == 0) s = {b0.count, b0.wr_addr, b0.rd_addr, b0.full, b0.empty, b0.afull, b0.aempty, b0.overflow, b0.underflow};
    else        s = {b1.count, b1.wr_addr, b1.rd_addr, b1.full, b1.empty, b1.afull, b1.aempty, b1.overflow, b1.underflow};
    return s;
  endfunction

  function automatic logic [1:0] exp_stb(int k);
    return {wr && (m_cnt[k] != D[k]), rd && (m_cnt[k] != 0)};
  endfunction

  function automatic logic [1:0] obs_stb(int k);
    return (k == 0) ? {b0.wr_en_o, b0.rd_en_o} : {b1.wr_en_o, b1.rd_en_o};
  endfunction

  task automatic apply(input bit w, input bit r, input bit c);
    @(negedge clk);
    wr = w; rd = r; clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_st(k) !== exp_st(k)) begin
        failures++; $display("FAIL reset dut%0d state got=%h exp=%h", k, obs_st(k), exp_st(k));
      end
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 18; i++) begin
      apply(i < 17, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_stb(k) !== exp_stb(k)) begin
          failures++; $display("FAIL fill_strobe dut%0d i=%0d got=%b exp=%b", k, i, obs_stb(k), exp_stb(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_st(k) !== exp_st(k)) begin
          failures++; $display("FAIL fill dut%0d i=%0d got=%h exp=%h", k, i, obs_st(k), exp_st(k));
        end
      end
    end
  endtask

  task automatic test_full_rw();
    apply(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_stb(k) !== exp_stb(k)) begin
        failures++; $display("FAIL full_rw_strobe dut%0d got=%b exp=%b", k, obs_stb(k), exp_stb(k));
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_st(k) !== exp_st(k)) begin
        failures++; $display("FAIL full_rw dut%0d got=%h exp=%h", k, obs_st(k), exp_st(k));
      end
    end
  endtask

  // Drain past empty, then a coincident read+write from empty, then idle.
  task automatic test_drain_underflow();
    for (int i = 0; i < 20; i++) begin
      bit w, r;
      w = (i == 18); r = (i < 19);
      apply(w, r, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_stb(k) !== exp_stb(k)) begin
          failures++; $display("FAIL drain_strobe dut%0d i=%0d got=%b exp=%b", k, i, obs_stb(k), exp_stb(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_st(k) !== exp_st(k)) begin
          failures++; $display("FAIL drain dut%0d i=%0d got=%h exp=%h", k, i, obs_st(k), exp_st(k));
        end
      end
    end
  endtask

  task automatic test_random_wrap();
    for (int i = 0; i < 120; i++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      apply(w, r, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_stb(k) !== exp_stb(k)) begin
          failures++; $display("FAIL rand_strobe dut%0d i=%0d got=%b exp=%b", k, i, obs_stb(k), exp_stb(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_st(k) !== exp_st(k)) begin
          failures++; $display("FAIL rand dut%0d i=%0d got=%h exp=%h", k, i, obs_st(k), exp_st(k));
        end
      end
    end
  endtask

  // Assert reset between edges at count 7 and check it takes effect with no clock.
  task automatic test_async_reset();
    apply(1'b0, 1'b0, 1'b0);
    reset = 1'b0; #1; model_reset();
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_st(k) !== exp_st(k)) begin
        failures++; $display("FAIL async_reset dut%0d got=%h exp=%h", k, obs_st(k), exp_st(k));
      end
    end
    apply(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_steady();
    for (int i = 0; i < 13; i++) begin
      apply(1'b1, i >= 5, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_st(k) !== exp_st(k)) begin
          failures++; $display("FAIL steady dut%0d i=%0d got=%h exp=%h", k, i, obs_st(k), exp_st(k));
        end
      end
    end
  endtask

  // Overflow held, cleared, then clear coincident with a fresh overflow.
  task automatic test_err_clr();
    bit w_seq[24], c_seq[24];
    for (int i = 0; i < 24; i++) begin
      w_seq[i] = (i < 16) || (i == 18);
      c_seq[i] = (i == 16) || (i == 18) || (i == 20) || (i == 22);
    end
    for (int i = 0; i < 24; i++) begin
      apply(w_seq[i], 1'b0, c_seq[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_st(k) !== exp_st(k)) begin
          failures++; $display("FAIL err_clr dut%0d i=%0d got=%h exp=%h", k, i, obs_st(k), exp_st(k));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_drain_underflow();
    test_random_wrap();
    test_async_reset();
    test_steady();
    test_err_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
